// File: rtl/bcd_counter_pkg.sv
// Shared constants and helpers for the BCD counter slice.
// Segment patterns are active-low, bit0 = a through bit6 = g.
package bcd_counter_pkg;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decimal digit patterns; index 0 is the rightmost entry.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: holds a 0..9 digit, steps when enabled by the chain below it,
// and forwards carry (up) or borrow (down) to the next decade.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  logic [3:0] next_c;

  always_comb begin
    next_c = digit;
    if (up) next_c = (digit == DIGIT_MAX) ? 4'd0 : digit + 4'd1;
    else    next_c = (digit == 4'd0) ? DIGIT_MAX : digit - 4'd1;
  end

  assign cout = cin && (up ? (digit == DIGIT_MAX) : (digit == 4'd0));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)             digit <= 4'd0;
    else if (clear)         digit <= 4'd0;
    else if (load)          digit <= (load_digit > DIGIT_MAX) ? DIGIT_MAX : load_digit;
    else if (step && cin)   digit <= next_c;
  end

endmodule

// File: rtl/hex7segment.sv
// Hex digit to active-low seven-segment pattern (bit0 = a ... bit6 = g).
module hex7segment
  import bcd_counter_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_TABLE[hex];
    endcase
  end

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with prescaler, load/clear, wrap or
// saturate at the limits, and per-digit seven-segment outputs.
module bcd_counter
  import bcd_counter_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned TICK_HZ  = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  tick,
  output logic                  carry
);

  localparam int unsigned DIV  = (TICK_HZ == 0) ? 0 : CLK_HZ / TICK_HZ;
  localparam int unsigned PS_W = (clog2(DIV) == 0) ? 1 : clog2(DIV);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'((DIV == 0) ? 0 : DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("bcd_counter: CLK_HZ/TICK_HZ must be at least 1");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_counter: DIGITS must be in 1..8");
  end

  logic [PS_W-1:0] prescale;
  logic [DIGITS:0] chain;
  logic            step_c;
  logic            limit_c;
  logic            advance_c;
  logic            digit_step_c;

  // chain[DIGITS] is high only when every digit sits at the limit for the direction.
  assign chain[0]     = 1'b1;
  assign limit_c      = chain[DIGITS];
  assign step_c       = en && (prescale == PS_MAX);
  assign advance_c    = step_c && !clear && !load;
  assign digit_step_c = step_c && !(SATURATE && limit_c);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)              prescale <= '0;
    else if (clear || load)  prescale <= '0;
    else if (en)             prescale <= step_c ? '0 : prescale + PS_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick  <= 1'b0;
      carry <= 1'b0;
    end else begin
      tick  <= advance_c;
      carry <= advance_c && limit_c;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .clear      (clear),
      .load       (load),
      .load_digit (load_val[4*g +: 4]),
      .step       (digit_step_c),
      .up         (up),
      .cin        (chain[g]),
      .digit      (bcd[4*g +: 4]),
      .cout       (chain[g+1])
    );

    hex7segment u_seg (
      .hex (bcd[4*g +: 4]),
      .seg (seg[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench for bcd_counter: a wrapping and a saturating instance share
// one stimulus stream (DIGITS=2, DIV=10).
module tb_bcd_counter;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        en;
  logic        up;
  logic        clear;
  logic        load;
  logic [7:0]  load_val;

  logic [7:0]  bcd_w, bcd_s;
  logic [13:0] seg_w, seg_s;
  logic        tick_w, tick_s;
  logic        carry_w, carry_s;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk_in = ~clk_in;

  bcd_counter #(.DIGITS(2), .CLK_HZ(10), .TICK_HZ(1), .SATURATE(1'b0)) u_w (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .up(up), .clear(clear),
    .load(load), .load_val(load_val), .bcd(bcd_w), .seg(seg_w),
    .tick(tick_w), .carry(carry_w)
  );

  bcd_counter #(.DIGITS(2), .CLK_HZ(10), .TICK_HZ(1), .SATURATE(1'b1)) u_s (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .up(up), .clear(clear),
    .load(load), .load_val(load_val), .bcd(bcd_s), .seg(seg_s),
    .tick(tick_s), .carry(carry_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until tick is seen, bounded at 30.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk_in);
      cycles++;
    end while (!tick_w && cycles < 30);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = 8'h00;

    // reset and first interval
    repeat (2) @(negedge clk_in);
    check("rst_bcd",   32'(bcd_w), 32'h00);
    check("rst_seg",   32'(seg_w), 32'h2040);
    check("rst_tick",  32'(tick_w), 32'h0);
    check("rst_carry", 32'(carry_s), 32'h0);
    rst_n = 1'b1;
    wait_tick(n);
    check("first_tick_cycles", 32'(n), 32'd10);
    check("first_bcd",   32'(bcd_w), 32'h01);
    check("first_carry", 32'(carry_w), 32'h0);
    @(negedge clk_in);
    check("tick_one_cycle", 32'(tick_w), 32'h0);

    // count up across the top
    load = 1'b1; load_val = 8'h98;
    @(negedge clk_in);
    load = 1'b0;
    check("load98_w", 32'(bcd_w), 32'h98);
    check("load98_s", 32'(bcd_s), 32'h98);
    wait_tick(n);
    check("up1_cycles", 32'(n), 32'd10);
    check("up1_bcd_w", 32'(bcd_w), 32'h99);
    check("up1_carry_w", 32'(carry_w), 32'h0);
    check("up1_bcd_s", 32'(bcd_s), 32'h99);
    wait_tick(n);
    check("up2_cycles", 32'(n), 32'd10);
    check("up2_bcd_w", 32'(bcd_w), 32'h00);
    check("up2_carry_w", 32'(carry_w), 32'h1);
    check("up2_bcd_s", 32'(bcd_s), 32'h99);
    check("up2_tick_s", 32'(tick_s), 32'h1);
    check("up2_carry_s", 32'(carry_s), 32'h1);

    // count down across the bottom
    load = 1'b1; load_val = 8'h01; up = 1'b0;
    @(negedge clk_in);
    load = 1'b0;
    check("load01", 32'(bcd_s), 32'h01);
    wait_tick(n);
    check("dn1_bcd_s", 32'(bcd_s), 32'h00);
    check("dn1_carry_s", 32'(carry_s), 32'h0);
    check("dn1_bcd_w", 32'(bcd_w), 32'h00);
    wait_tick(n);
    check("dn2_bcd_s", 32'(bcd_s), 32'h00);
    check("dn2_carry_s", 32'(carry_s), 32'h1);
    check("dn2_bcd_w", 32'(bcd_w), 32'h99);
    check("dn2_carry_w", 32'(carry_w), 32'h1);
    wait_tick(n);
    check("dn3_bcd_s", 32'(bcd_s), 32'h00);
    check("dn3_carry_s", 32'(carry_s), 32'h1);
    check("dn3_bcd_w", 32'(bcd_w), 32'h98);
    check("dn3_carry_w", 32'(carry_w), 32'h0);

    // clamp on load, then clear+load on a step edge
    load = 1'b1; load_val = 8'hA5;
    @(negedge clk_in);
    load = 1'b0;
    check("clamp_bcd", 32'(bcd_w), 32'h95);
    check("clamp_seg", 32'(seg_w), 32'h0812);
    repeat (9) @(negedge clk_in);
    check("pre_step_prescale", 32'(u_w.prescale), 32'd9);
    clear = 1'b1; load = 1'b1; load_val = 8'h33;
    @(negedge clk_in);
    clear = 1'b0; load = 1'b0;
    check("clr_bcd", 32'(bcd_w), 32'h00);
    check("clr_tick", 32'(tick_w), 32'h0);
    check("clr_carry", 32'(carry_w), 32'h0);

    // pause mid-interval
    repeat (4) @(negedge clk_in);
    check("pause_prescale_in", 32'(u_w.prescale), 32'd4);
    en = 1'b0;
    repeat (7) @(negedge clk_in);
    check("pause_prescale", 32'(u_w.prescale), 32'd4);
    check("pause_bcd", 32'(bcd_w), 32'h00);
    check("pause_tick", 32'(tick_w), 32'h0);
    en = 1'b1;
    @(negedge clk_in);
    check("resume_prescale", 32'(u_w.prescale), 32'd5);
    wait_tick(n);
    check("resume_cycles", 32'(n), 32'd5);
    check("resume_bcd_w", 32'(bcd_w), 32'h99);
    check("resume_bcd_s", 32'(bcd_s), 32'h00);

    // asynchronous reset with a tick pending
    load = 1'b1; load_val = 8'h56; up = 1'b1;
    @(negedge clk_in);
    load = 1'b0;
    wait_tick(n);
    check("pre_rst_bcd", 32'(bcd_w), 32'h57);
    check("pre_rst_seg", 32'(seg_w), 32'h0978);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bcd_w", 32'(bcd_w), 32'h00);
    check("arst_tick", 32'(tick_w), 32'h0);
    check("arst_seg", 32'(seg_w), 32'h2040);
    check("arst_bcd_s", 32'(bcd_s), 32'h00);
    @(negedge clk_in);
    rst_n = 1'b1;
    wait_tick(n);
    check("post_rst_cycles", 32'(n), 32'd10);
    check("post_rst_bcd", 32'(bcd_w), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter.md
Name: bcd_counter

Overview:
- Parametrised multi-digit BCD up/down counter with a built-in prescaler and per-digit seven-segment outputs.
- Replaces the fixed one-hertz divider, 4-bit binary counter and binary-to-decimal path in the board top level.
- Supports N decimal digits, a programmable step rate, up/down direction, parallel load, and wrap or saturate at the limits.

Parameters:
- DIGITS, 2, number of BCD digits (1..8).
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1, step rate. DIV = CLK_HZ/TICK_HZ; DIV >= 1 is required (elaboration error otherwise).
- SATURATE, 0, 0 = wrap at the limits; 1 = hold at the limits.

Ports:
- clk_in  in  1  system clock (CLOCK_50 at top level)
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  1 = prescaler runs; 0 = prescaler and count hold
- up  in  1  1 = count up, 0 = count down; sampled on the step cycle
- clear  in  1  synchronous clear of count and prescaler
- load  in  1  synchronous parallel load
- load_val  in  4*DIGITS  BCD load value; digit i at [4i+3:4i]
- bcd  out  4*DIGITS  registered count; digit i at [4i+3:4i]
- seg  out  7*DIGITS  active-low segments; digit i at [7i+6:7i], bit0 = a … bit6 = g
- tick  out  1  registered one-cycle step strobe
- carry  out  1  registered one-cycle wrap/limit strobe

Behaviour:
- Reset (rst_n=0, asynchronous): prescale=0, bcd=0, tick=0, carry=0. seg then shows all digits "0" (7'b1000000 each).
- Prescaler: counter of width clog2(DIV), range 0..DIV-1.
  - en=1 and prescale==DIV-1: prescale becomes 0 and a step occurs at this edge.
  - en=1 otherwise: prescale increments.
  - en=0: prescale holds.
  - DIV=1: a step occurs every enabled cycle.
- tick goes high the cycle after a step edge, for exactly one cycle. It is aligned with the new bcd value.
- Priority per edge: clear > load > step.
  - clear: bcd=0, prescale=0, no tick, no carry.
  - load: each digit takes load_val; any digit >9 is clamped to 9. prescale=0, no tick, no carry.
  - A step coinciding with clear or load is dropped.
- Step up (up=1):
  - Digit 0 increments. A digit at 9 becomes 0 and carries into the next digit (ripple across all DIGITS in one cycle).
  - At all-9s: SATURATE=0 wraps to all-0s; SATURATE=1 holds. carry pulses in both cases.
- Step down (up=0):
  - Digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - At all-0s: SATURATE=0 wraps to all-9s; SATURATE=1 holds. carry pulses in both cases.
- carry is asserted in the same cycle as the matching tick. It is never asserted without tick.
- A direction change takes effect on the next step. No glitch, no extra step.
- seg is combinational from the bcd register, giving zero latency relative to bcd. Only codes 0-9 can reach the decoder.
- Reset mid-count: asserting rst_n asynchronously clears all state, including a pending tick or carry. Counting resumes from 0 after release, with a full DIV-cycle interval to the first step.
- en deasserted mid-interval: the interval resumes where it paused, without restarting.

Decomposition:
- Shared package holds:
  - Seven-segment constant table (0-9, active-low).
  - SEG_BLANK = 7'b1111111.
  - DIGIT_MAX = 4'd9.
  - Function clog2.
- One sub-module, bcd_digit: 4-bit BCD cell.
  - Inputs: step, up, carry/borrow in.
  - Outputs: digit, carry/borrow out.
  - Instantiated DIGITS times in a generate loop with the carry chain between cells.
- Segment decode reuses the existing hex7segment, one instance per digit.

Test Plan:
- Reset and idle: DIGITS=2, CLK_HZ=10, TICK_HZ=1, en=1, rst_n low then released → bcd=8'h00, seg=14'h2040. First tick at cycle 10 after release, then bcd=8'h01.
- Count up with wrap: load 8'h98, up=1, SATURATE=0, run 2 steps → 8'h99, then 8'h00 with carry=1 coincident with tick on the second step only.
- Count down with saturate: SATURATE=1, load 8'h01, up=0, run 3 steps → 8'h00, 8'h00 (carry=1), 8'h00 (carry=1).
- Priority and clamping: load_val=8'hA5 with load=1 and clear=0 → bcd=8'h95. clear and load together on a step edge → bcd=8'h00, no tick, no carry.
- Enable pause: en=0 for 7 cycles mid-interval (prescale=4) → bcd and prescale frozen. After re-enable, the next tick arrives 5 cycles later.
- Async reset mid-operation: bcd=8'h57, pull rst_n low between clock edges → bcd=0 and tick=0 immediately, with no clock edge required.
